sseg_capture: RTL and testbench

- Receive side of the multiplexed seven-segment interface. Samples the active-low segment and anode lines driven by the display driver and reconstructs the four displayed hex digits plus decimal points.
- Used for loopback self-test of the display path, and as a bench monitor in place of the physical display.
- Publishes a coherent four-digit frame only after every digit position has been seen with a stable, legal pattern.

---
 rtl/sseg_capture.sv | 158 +++++++++++++++
 tb/tb_sseg_capture.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// sseg_capture: receive side of the multiplexed seven-segment link.
// Rebuilds the four displayed hex digits and decimal points from the sampled lines.
//
// state  | meaning
// IDLE   | no anode selected
// SETTLE | anode selected, waiting for the sample word to stay put
// HOLD   | current dwell already evaluated, waiting for the next change
module sseg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SEGMENTS,
  input  logic [3:0]  ANODES,
  output logic [15:0] DIGITS,
  output logic [3:0]  DP,
  output logic        VALID,
  output logic        FRAME_DONE,
  output logic        ERR
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_ARM   = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    seg_meta, seg_sync;
  logic [3:0]    an_meta, an_sync;
  logic [11:0]   sample, sample_prev;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [3:0]    seen, seen_nxt;
  logic          same, all_off, stable_hit;
  logic          eval, one_low, dec_hit, acc, bad, commit, tmo_hit;
  logic [1:0]    dig_idx;
  logic [3:0]    dec_val;

  function automatic logic [4:0] decode7(input logic [6:0] lit);
    case (lit)
      7'h3F: return {1'b1, 4'h0};
      7'h06: return {1'b1, 4'h1};
      7'h5B: return {1'b1, 4'h2};
      7'h4F: return {1'b1, 4'h3};
      7'h66: return {1'b1, 4'h4};
      7'h6D: return {1'b1, 4'h5};
      7'h7D: return {1'b1, 4'h6};
      7'h07: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h6F: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h7C: return {1'b1, 4'hB};
      7'h39: return {1'b1, 4'hC};
      7'h5E: return {1'b1, 4'hD};
      7'h79: return {1'b1, 4'hE};
      7'h71: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  assign sample  = {an_sync, seg_sync};
  assign same    = (sample == sample_prev);
  assign all_off = &an_sync;
  // the matching sample of this cycle completes a run of STABLE_CYCLES identical words
  assign stable_hit = same && (stab_cnt >= STABLE_ARM);
  assign {dec_hit, dec_val} = decode7(~seg_sync[6:0]);

  always_comb begin
    dig_idx = 2'd0;
    one_low = 1'b1;
    case (an_sync)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!all_off) state_nxt = SETTLE;
      SETTLE:  if (all_off) state_nxt = IDLE;
               else if (stable_hit) state_nxt = HOLD;
      HOLD:    if (!same) state_nxt = all_off ? IDLE : SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    eval    = (state == SETTLE) && !all_off && stable_hit;
    acc     = eval && one_low && dec_hit;
    bad     = eval && !(one_low && dec_hit);
    commit  = (seen == 4'hF);
    tmo_hit = !acc && (tmo_cnt == TIMEOUT_LAST);
    seen_nxt = seen;
    if (commit || tmo_hit) seen_nxt = 4'h0;
    if (acc) seen_nxt[dig_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_meta    <= '0;
      seg_sync    <= '0;
      an_meta     <= '0;
      an_sync     <= '0;
      sample_prev <= '0;
      stab_cnt    <= '0;
      tmo_cnt     <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      seen        <= '0;
      DIGITS      <= '0;
      DP          <= '0;
      VALID       <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      seg_meta    <= SEGMENTS;
      seg_sync    <= seg_meta;
      an_meta     <= ANODES;
      an_sync     <= an_meta;
      sample_prev <= sample;
      if (!same)                   stab_cnt <= '0;
      else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + SW'(1);
      if (acc)                     tmo_cnt <= '0;
      else if (tmo_cnt != TIMEOUT_MAX) tmo_cnt <= tmo_cnt + TW'(1);
      seen       <= seen_nxt;
      FRAME_DONE <= commit;
      if (bad) ERR <= 1'b1;
      // commit copies the shadow as it stood before any write on this edge
      if (commit) begin
        DIGITS <= shadow;
        DP     <= shadow_dp;
        VALID  <= 1'b1;
      end
      if (tmo_hit) VALID <= 1'b0;
      if (acc) begin
        shadow[{dig_idx, 2'b00} +: 4] <= dec_val;
        shadow_dp[dig_idx]            <= ~seg_sync[7];
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed scans from the test plan plus random dwells,
// all checked cycle by cycle against a run-length/event model of the receiver.
module tb_sseg_capture;
  localparam int STABLE = 16;
  localparam int TMO    = 3000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  SEGMENTS;
  logic [3:0]  ANODES;
  logic [15:0] DIGITS;
  logic [3:0]  DP;
  logic        VALID, FRAME_DONE, ERR;

  sseg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .SEGMENTS(SEGMENTS), .ANODES(ANODES),
    .DIGITS(DIGITS), .DP(DP), .VALID(VALID), .FRAME_DONE(FRAME_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;
  bit cmp_en = 1'b0;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // model state: inputs delayed two cycles, run length of identical words,
  // cycles since the last accepted digit
  logic [7:0]  m_seg1, m_seg2;
  logic [3:0]  m_an1, m_an2;
  logic [11:0] m_prev;
  int          m_run, m_since;
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_sdp, m_seen, m_dp;
  logic [15:0] m_digits;
  logic        m_valid, m_fd, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [11:0] s;
    int nlow, idx, val;
    bit acc;
    if (RST) begin
      m_seg1 = 0; m_seg2 = 0; m_an1 = 0; m_an2 = 0;
      m_prev = 0; m_run = 1; m_since = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 0;
      m_sdp = 0; m_seen = 0; m_digits = 0; m_dp = 0;
      m_valid = 0; m_fd = 0; m_err = 0;
      return;
    end
    s = {m_an2, m_seg2};
    m_run = (s == m_prev) ? m_run + 1 : 1;
    m_prev = s;
    acc = 0;
    m_fd = (m_seen == 4'hF);
    if (m_fd) begin
      m_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
      m_dp = m_sdp;
      m_valid = 1;
      m_seen = 0;
    end
    if (m_run == STABLE && s[11:8] != 4'hF) begin
      nlow = 0; idx = 0; val = -1;
      for (int i = 0; i < 4; i++) if (!s[8+i]) begin nlow++; idx = i; end
      for (int v = 0; v < 16; v++) if (glyph[v][6:0] == ~s[6:0]) val = v;
      if (nlow == 1 && val >= 0) begin
        m_shadow[idx] = 4'(val);
        m_sdp[idx] = ~s[7];
        m_seen[idx] = 1'b1;
        acc = 1;
      end else m_err = 1;
    end
    if (acc) m_since = 0;
    else if (m_since < TMO) begin
      m_since++;
      if (m_since == TMO) begin m_valid = 0; m_seen = 0; end
    end
    m_seg2 = m_seg1; m_seg1 = SEGMENTS;
    m_an2 = m_an1;   m_an1 = ANODES;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (cmp_en) begin
      check("digits", DIGITS, m_digits);
      check("dp", DP, m_dp);
      check("valid", VALID, m_valid);
      check("frame_done", FRAME_DONE, m_fd);
      check("err", ERR, m_err);
      if (FRAME_DONE) fd_seen++;
    end
  end

  // all drive tasks start and end on a falling edge
  task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int n);
    ANODES = an;
    SEGMENTS = seg;
    repeat (n) @(negedge CLK);
  endtask

  task automatic put(input int d, input logic [7:0] seg, input bit glitch);
    logic [3:0] an;
    an = 4'hF;
    an[d] = 1'b0;
    if (glitch) begin
      dwell(an, 8'h80, 5);
      dwell(an, seg, 35);
    end else dwell(an, seg, 40);
  endtask

  task automatic tail();
    dwell(4'hF, 8'hFF, 2 + STABLE + 1 + 6);
  endtask

  initial begin
    logic [3:0] an;
    logic [7:0] seg;
    int r;
    RST = 1'b1; ANODES = 4'hF; SEGMENTS = 8'hFF;
    repeat (3) @(negedge CLK);
    cmp_en = 1'b1;
    check("rst_digits", DIGITS, 16'h0);
    check("rst_dp", DP, 4'h0);
    check("rst_valid", VALID, 1'b0);
    check("rst_fd", FRAME_DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    RST = 1'b0;

    // plain scan 3..0 showing 1,2,3,4
    put(3, 8'hF9, 0); put(2, 8'hA4, 0); put(1, 8'hB0, 0); put(0, 8'h99, 0); tail();
    check("scan_digits", DIGITS, 16'h1234);
    check("scan_model_digits", m_digits, 16'h1234);
    check("scan_dp", DP, 4'h0);
    check("scan_valid", VALID, 1'b1);
    check("scan_err", ERR, 1'b0);
    check("scan_fd_count", fd_seen, 1);

    // short glitch at the start of every dwell is ignored
    put(3, 8'hF9, 1); put(2, 8'hA4, 1); put(1, 8'hB0, 1); put(0, 8'h99, 1); tail();
    check("glitch_digits", DIGITS, 16'h1234);
    check("glitch_err", ERR, 1'b0);
    check("glitch_fd_count", fd_seen, 2);

    // digit 0 shows 8 with its decimal point lit, scan order 0..3
    put(0, 8'h00, 0); put(1, 8'hB0, 0); put(2, 8'hA4, 0); put(3, 8'hF9, 0); tail();
    check("dp8_digits", DIGITS, 16'h1238);
    check("dp8_dp", DP, 4'b0001);
    check("dp8_model_dp", m_dp, 4'b0001);

    // illegal pattern on digit 2, then two anodes at once
    put(3, 8'hF9, 0); put(2, 8'hFE, 0); put(1, 8'hB0, 0); put(0, 8'h99, 0); tail();
    check("illegal_err", ERR, 1'b1);
    check("illegal_model_err", m_err, 1'b1);
    check("illegal_fd_count", fd_seen, 3);
    dwell(4'b0011, 8'hF9, 40); tail();
    check("multi_err", ERR, 1'b1);
    check("multi_fd_count", fd_seen, 3);
    put(2, 8'hA4, 0); tail();
    check("repair_digits", DIGITS, 16'h1234);
    check("repair_fd_count", fd_seen, 4);
    check("repair_err_sticky", ERR, 1'b1);

    // timeout with anodes idle, then a fresh frame 9,8,7,6 on digits 0..3
    dwell(4'hF, 8'hFF, TMO - 200);
    check("pre_tmo_valid", VALID, 1'b1);
    dwell(4'hF, 8'hFF, 300);
    check("tmo_valid", VALID, 1'b0);
    check("tmo_model_valid", m_valid, 1'b0);
    check("tmo_digits_hold", DIGITS, 16'h1234);
    put(0, 8'h90, 0); put(1, 8'h80, 0); put(2, 8'hF8, 0); put(3, 8'h82, 0); tail();
    check("renew_digits", DIGITS, 16'h6789);
    check("renew_valid", VALID, 1'b1);
    check("renew_fd_count", fd_seen, 5);

    // reset after three digits discards the partial frame
    put(3, 8'hF9, 0); put(2, 8'hA4, 0); put(1, 8'hB0, 0);
    RST = 1'b1;
    dwell(4'hF, 8'hFF, 2);
    RST = 1'b0;
    check("midrst_digits", DIGITS, 16'h0);
    check("midrst_err", ERR, 1'b0);
    put(0, 8'h99, 0); tail();
    check("midrst_partial_fd", fd_seen, 5);
    put(3, 8'hF9, 0); put(2, 8'hA4, 0); put(1, 8'hB0, 0); tail();
    check("midrst_fd_count", fd_seen, 6);
    check("midrst_frame", DIGITS, 16'h1234);

    // random dwells, checked by the per-cycle model
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 19);
      an = 4'hF;
      an[$urandom_range(0, 3)] = 1'b0;
      if (r == 0) an = 4'hF;
      else if (r == 1) an = 4'($urandom);
      seg = ~{1'($urandom), glyph[$urandom_range(0, 15)][6:0]};
      if (r == 2) seg = 8'($urandom);
      if (r == 3) begin
        RST = 1'b1;
        dwell(an, seg, 2);
        RST = 1'b0;
      end
      dwell(an, seg, $urandom_range(3, 45));
    end
    tail();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
